// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings, FSM states
// and operation-class helpers used by both this block and the controller.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic md_is_mul(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_launch(input logic [3:0] op);
    return md_is_mul(op) || md_is_div(op);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at launch and held until the cycle counter expires.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [63:0]       res_q, res_d;
  logic              skip_q, skip_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag, b_safe;
  logic [31:0]        q_mag, r_mag, quot, rem;
  logic [63:0]        calc;
  logic               launch;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division via magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of hitting the overflow case of a native signed divide.
  assign a_neg  = (MDOp == MD_DIV) && A[31];
  assign b_neg  = (MDOp == MD_DIV) && B[31];
  assign a_mag  = a_neg ? (~A + 32'd1) : A;
  assign b_mag  = b_neg ? (~B + 32'd1) : B;
  assign b_safe = (b_mag == '0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    calc = '0;
    case (MDOp)
      MD_MULT:          calc = prod_s;
      MD_MULTU:         calc = prod_u;
      MD_DIV, MD_DIVU:  calc = {rem, quot};
      default:          calc = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    skip_d  = skip_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    launch  = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (Start && md_is_launch(MDOp)) begin
          launch = 1'b1;
        end else if (MDOp == MD_MTHI) begin
          hi_d = A;
        end else if (MDOp == MD_MTLO) begin
          lo_d = A;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (!skip_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
          state_d = MD_IDLE;
          // Back-to-back launch on the commit edge.
          launch = Start && md_is_launch(MDOp);
        end
      end
      default: state_d = MD_IDLE;
    endcase

    if (launch) begin
      state_d = MD_BUSY;
      res_d   = calc;
      cnt_d   = md_is_mul(MDOp) ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
      skip_d  = md_is_div(MDOp) && (B == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      skip_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      skip_q  <= skip_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == MD_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    Out = '0;
    if (MDOp == MD_MFHI)      Out = hi_q;
    else if (MDOp == MD_MFLO) Out = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected HI/LO/busy
// length, a negedge monitor checks each commit when Busy falls.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO, Out;

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   abort    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a falling Busy marks a commit (or an aborted op after reset).
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (Busy === 1'b1) begin
      busy_cnt++;
    end else if (prev_busy) begin
      if (abort) begin
        abort = 1'b0;
      end else if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit: got HI=%h LO=%h expected no commit", HI, LO);
      end else begin
        e = q.pop_front();
        check("commit_HI", HI, e.hi);
        check("commit_LO", LO, e.lo);
        check("busy_cycles", 32'(busy_cnt), 32'(e.cyc));
      end
      busy_cnt = 0;
    end
    prev_busy = (Busy === 1'b1);
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eh, input logic [31:0] el,
                       input int cyc);
    exp_t e;
    @(negedge clk);
    Start = 1'b1; MDOp = op; A = a; B = b;
    if (push) begin
      e.hi = eh; e.lo = el; e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1 Start = 1'b0; MDOp = 4'd0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    MDOp = op; A = a;
    @(posedge clk);
    #1 MDOp = 4'd0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && Busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = 4'd0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_Busy", {31'd0, Busy}, 32'd0);
    check("reset_HI", HI, 32'd0);
    check("reset_LO", LO, 32'd0);
    check("reset_Out", Out, 32'd0);

    // Multiplies
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    wait_idle();
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 5);
    wait_idle();
    issue(4'd1, 32'h00010000, 32'h00010000, 1, 32'h00000001, 32'h00000000, 5);
    wait_idle();

    // Divides
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    wait_idle();
    issue(4'd4, 32'd7, 32'd2, 1, 32'd1, 32'd3, 10);
    wait_idle();
    issue(4'd3, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 32'hFFFFFFFD, 10);
    wait_idle();
    issue(4'd4, 32'hFFFFFFF9, 32'd2, 1, 32'd1, 32'h7FFFFFFC, 10);
    wait_idle();

    // Start and MTHI while busy are ignored
    issue(4'd3, 32'd100, 32'd7, 1, 32'd2, 32'd14, 10);
    issue(4'd1, 32'd3, 32'd4, 0, '0, '0, 0);
    mt(4'd5, 32'h1234);
    wait_idle();
    repeat (12) @(negedge clk);
    check("ignored_start_Busy", {31'd0, Busy}, 32'd0);
    check("ignored_mthi_HI", HI, 32'd2);

    // Start with non-launch op is ignored
    issue(4'd9, 32'd5, 32'd5, 0, '0, '0, 0);
    @(negedge clk);
    check("op9_Busy", {31'd0, Busy}, 32'd0);
    check("op9_LO", LO, 32'd14);

    // Divide by zero keeps HI/LO; most-negative / -1
    mt(4'd5, 32'hAA);
    mt(4'd6, 32'hBB);
    @(negedge clk);
    check("mthi_HI", HI, 32'hAA);
    check("mtlo_LO", LO, 32'hBB);
    issue(4'd3, 32'd5, 32'd0, 1, 32'hAA, 32'hBB, 10);
    wait_idle();
    issue(4'd4, 32'd5, 32'd0, 1, 32'hAA, 32'hBB, 10);
    wait_idle();
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 32'h80000000, 10);
    wait_idle();

    // Reset mid-multiply aborts without commit
    issue(4'd1, 32'd3, 32'd4, 0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_Busy", {31'd0, Busy}, 32'd0);
    check("abort_HI", HI, 32'd0);
    check("abort_LO", LO, 32'd0);
    repeat (10) @(negedge clk);
    check("abort_late_HI", HI, 32'd0);
    check("abort_late_LO", LO, 32'd0);

    // Read-out mux
    mt(4'd6, 32'd5);
    mt(4'd5, 32'h77);
    @(negedge clk);
    MDOp = 4'd8;
    #1 check("mflo_Out", Out, 32'd5);
    MDOp = 4'd7;
    #1 check("mfhi_Out", Out, 32'h77);
    MDOp = 4'd12;
    #1 check("none_Out", Out, 32'd0);
    MDOp = 4'd0;

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
